keypad_pin_entry: RTL

- Input side of the lock: scans a 4x4 matrix keypad, debounces presses and assembles the 4-digit PIN.
- Runs the lock state machine and produces pin0..pin3 and status, which the 7-segment/display block consumes.
- Empty PIN slot is 4'hF; status 1 = open, 0 = locked.
- Runs on the same 500 Hz display clock.

---
 rtl/keypad_pin_entry.sv | 293 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_pin_entry.sv
// Keypad front end for the lock: column scan, debounce, PIN assembly and the
// lock state machine feeding the 7-segment display block.
module keypad_pin_entry #(
    parameter logic [15:0] CODE           = 16'h1234,
    parameter int          DEBOUNCE_SCANS = 3,
    parameter int          MAX_FAILS      = 3,
    parameter int          LOCKOUT_TICKS  = 1500
) (
    input  logic       clk_500Hz,
    input  logic       rst_n,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] pin0,
    output logic [3:0] pin1,
    output logic [3:0] pin2,
    output logic [3:0] pin3,
    output logic       status,
    output logic       lockout
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam int FW = $clog2(MAX_FAILS + 1);
    localparam int TW = (LOCKOUT_TICKS > 1) ? $clog2(LOCKOUT_TICKS) : 1;

    localparam logic [CW-1:0] DB_MAX     = CW'(DEBOUNCE_SCANS);
    localparam logic [FW-1:0] FAIL_MAX   = FW'(MAX_FAILS);
    localparam logic [FW-1:0] FAIL_LAST  = FW'(MAX_FAILS - 1);
    localparam logic [TW-1:0] TICK_LAST  = TW'(LOCKOUT_TICKS - 1);
    localparam logic [15:0]   SLOTS_NONE = 16'hFFFF;

    localparam logic [1:0] DB_SCAN    = 2'd0;
    localparam logic [1:0] DB_PRESS   = 2'd1;
    localparam logic [1:0] DB_RELEASE = 2'd2;

    localparam logic [2:0] ST_LOCKED  = 3'd0;
    localparam logic [2:0] ST_CHECK   = 3'd1;
    localparam logic [2:0] ST_OPEN    = 3'd2;
    localparam logic [2:0] ST_SETCODE = 3'd3;
    localparam logic [2:0] ST_LOCKOUT = 3'd4;

    localparam logic [3:0] K_A    = 4'hA;
    localparam logic [3:0] K_STAR = 4'hE;
    localparam logic [3:0] K_HASH = 4'hF;

    // Key codes: digits are their value, A-D as hex, '*' = E, '#' = F.
    function automatic logic [3:0] key_of(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'b0000: k = 4'h1;
            4'b0001: k = 4'h2;
            4'b0010: k = 4'h3;
            4'b0011: k = 4'hA;
            4'b0100: k = 4'h4;
            4'b0101: k = 4'h5;
            4'b0110: k = 4'h6;
            4'b0111: k = 4'hB;
            4'b1000: k = 4'h7;
            4'b1001: k = 4'h8;
            4'b1010: k = 4'h9;
            4'b1011: k = 4'hC;
            4'b1100: k = K_STAR;
            4'b1101: k = 4'h0;
            4'b1110: k = K_HASH;
            default: k = 4'hD;
        endcase
        return k;
    endfunction

    // ---------------- scanner / debounce ----------------
    logic [1:0]    col_idx_q, col_idx_d;
    logic [3:0]    col_q, col_d;
    logic          phase_q, phase_d;
    logic [1:0]    db_mode_q, db_mode_d;
    logic [CW-1:0] db_cnt_q, db_cnt_d;
    logic [1:0]    key_row_q, key_row_d;
    logic          evt_q, evt_d;
    logic [3:0]    evt_key_q, evt_key_d;

    logic          one_low;
    logic [1:0]    row_idx;

    always_comb begin
        one_low = 1'b1;
        row_idx = 2'd0;
        case (row)
            4'b1110: row_idx = 2'd0;
            4'b1101: row_idx = 2'd1;
            4'b1011: row_idx = 2'd2;
            4'b0111: row_idx = 2'd3;
            default: one_low = 1'b0;
        endcase
    end

    // Row is sampled on the second clock of each column; that cadence is
    // kept while frozen on a column so debounce counts real scan samples.
    always_comb begin
        col_idx_d = col_idx_q;
        phase_d   = ~phase_q;
        db_mode_d = db_mode_q;
        db_cnt_d  = db_cnt_q;
        key_row_d = key_row_q;
        evt_d     = 1'b0;
        evt_key_d = evt_key_q;
        if (phase_q) begin
            case (db_mode_q)
                DB_SCAN: begin
                    if (one_low) begin
                        key_row_d = row_idx;
                        if (DEBOUNCE_SCANS <= 1) begin
                            evt_d     = 1'b1;
                            evt_key_d = key_of(row_idx, col_idx_q);
                            db_mode_d = DB_RELEASE;
                            db_cnt_d  = '0;
                        end else begin
                            db_mode_d = DB_PRESS;
                            db_cnt_d  = CW'(1);
                        end
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
                DB_PRESS: begin
                    if (!one_low) begin
                        db_mode_d = DB_SCAN;
                        db_cnt_d  = '0;
                        col_idx_d = col_idx_q + 2'd1;
                    end else if (row_idx != key_row_q) begin
                        key_row_d = row_idx;
                        db_cnt_d  = '0;
                    end else if (db_cnt_q + CW'(1) == DB_MAX) begin
                        evt_d     = 1'b1;
                        evt_key_d = key_of(row_idx, col_idx_q);
                        db_mode_d = DB_RELEASE;
                        db_cnt_d  = '0;
                    end else begin
                        db_cnt_d = db_cnt_q + CW'(1);
                    end
                end
                default: begin
                    if (row != 4'hF) begin
                        db_cnt_d = '0;
                    end else if (db_cnt_q + CW'(1) == DB_MAX) begin
                        db_mode_d = DB_SCAN;
                        db_cnt_d  = '0;
                        col_idx_d = col_idx_q + 2'd1;
                    end else begin
                        db_cnt_d = db_cnt_q + CW'(1);
                    end
                end
            endcase
        end
        col_d = ~(4'b0001 << col_idx_d);
    end

    always_ff @(posedge clk_500Hz or negedge rst_n) begin
        if (!rst_n) begin
            col_idx_q <= 2'd0;
            col_q     <= 4'b1110;
            phase_q   <= 1'b0;
            db_mode_q <= DB_SCAN;
            db_cnt_q  <= '0;
            key_row_q <= 2'd0;
            evt_q     <= 1'b0;
            evt_key_q <= 4'h0;
        end else begin
            col_idx_q <= col_idx_d;
            col_q     <= col_d;
            phase_q   <= phase_d;
            db_mode_q <= db_mode_d;
            db_cnt_q  <= db_cnt_d;
            key_row_q <= key_row_d;
            evt_q     <= evt_d;
            evt_key_q <= evt_key_d;
        end
    end

    // ---------------- lock state machine ----------------
    logic [2:0]      state_q, state_d;
    logic [3:0][3:0] pin_q, pin_d;     // pin_q[0] is the first digit
    logic [15:0]     code_q, code_d;
    logic [FW-1:0]   fails_q, fails_d;
    logic [TW-1:0]   tick_q, tick_d;

    logic [1:0]      slot_idx;
    logic            is_digit;

    always_comb begin
        slot_idx = 2'd3;
        for (int i = 3; i >= 0; i--) begin
            if (pin_q[i] == 4'hF) slot_idx = 2'(i);
        end
    end

    assign is_digit = (evt_key_q <= 4'd9);

    always_comb begin
        state_d = state_q;
        pin_d   = pin_q;
        code_d  = code_q;
        fails_d = fails_q;
        tick_d  = tick_q;
        case (state_q)
            ST_LOCKED: begin
                if (evt_q) begin
                    if (is_digit) begin
                        pin_d[slot_idx] = evt_key_q;
                        if (slot_idx == 2'd3) state_d = ST_CHECK;
                    end else if (evt_key_q == K_STAR) begin
                        pin_d = SLOTS_NONE;
                    end
                end
            end
            ST_CHECK: begin
                pin_d = SLOTS_NONE;
                if ({pin_q[0], pin_q[1], pin_q[2], pin_q[3]} == code_q) begin
                    state_d = ST_OPEN;
                    fails_d = '0;
                end else if (fails_q >= FAIL_LAST) begin
                    state_d = ST_LOCKOUT;
                    fails_d = FAIL_MAX;
                    tick_d  = '0;
                end else begin
                    state_d = ST_LOCKED;
                    fails_d = fails_q + FW'(1);
                end
            end
            ST_OPEN: begin
                pin_d = SLOTS_NONE;
                if (evt_q) begin
                    if (evt_key_q == K_HASH)   state_d = ST_LOCKED;
                    else if (evt_key_q == K_A) state_d = ST_SETCODE;
                end
            end
            ST_SETCODE: begin
                if (evt_q) begin
                    if (is_digit) begin
                        if (slot_idx == 2'd3) begin
                            code_d  = {pin_q[0], pin_q[1], pin_q[2], evt_key_q};
                            pin_d   = SLOTS_NONE;
                            state_d = ST_OPEN;
                        end else begin
                            pin_d[slot_idx] = evt_key_q;
                        end
                    end else if (evt_key_q == K_STAR) begin
                        pin_d   = SLOTS_NONE;
                        state_d = ST_OPEN;
                    end else if (evt_key_q == K_HASH) begin
                        pin_d   = SLOTS_NONE;
                        state_d = ST_LOCKED;
                    end
                end
            end
            ST_LOCKOUT: begin
                if (tick_q == TICK_LAST) begin
                    state_d = ST_LOCKED;
                    fails_d = '0;
                    tick_d  = '0;
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            default: begin
                state_d = ST_LOCKED;
                pin_d   = SLOTS_NONE;
            end
        endcase
    end

    always_ff @(posedge clk_500Hz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOCKED;
            pin_q   <= SLOTS_NONE;
            code_q  <= CODE;
            fails_q <= '0;
            tick_q  <= '0;
        end else begin
            state_q <= state_d;
            pin_q   <= pin_d;
            code_q  <= code_d;
            fails_q <= fails_d;
            tick_q  <= tick_d;
        end
    end

    assign col     = col_q;
    assign pin0    = pin_q[0];
    assign pin1    = pin_q[1];
    assign pin2    = pin_q[2];
    assign pin3    = pin_q[3];
    assign status  = (state_q == ST_OPEN) || (state_q == ST_SETCODE);
    assign lockout = (state_q == ST_LOCKOUT);

endmodule
